// File: rtl/irq_priority_controller.sv
// irq_priority_controller
//   Captures falling edges on active-low request lines into a pending register,
//   gates them with a programmable mask and presents the highest-index eligible
//   line to a host through an irq/ack handshake. The in-service line is tracked
//   until the host signals end-of-interrupt.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_n        active-low request lines; a 1->0 transition requests service
//   mask_we      mask register write strobe
//   mask_wdata   new mask value, 1 = line masked
//   ack          host accepts the presented vector
//   eoi          host finished servicing the in-service line
//   irq          registered interrupt request
//   vector       index of the presented or in-service line
//   pending      latched, not-yet-acknowledged requests
//   in_service   one-hot line being serviced, 0 when none
//   mask         current mask register
//   timeout_err  one-cycle pulse when irq is withdrawn for lack of ack
module irq_priority_controller #(
  parameter int unsigned N_REQ       = 8,
  parameter int unsigned VEC_W       = 3,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_n,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VEC_W-1:0] vector,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] in_service,
  output logic [N_REQ-1:0] mask,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   req_q;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   mask_q, mask_d;
  logic [N_REQ-1:0]   in_service_q, in_service_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   edge_set;
  logic [N_REQ-1:0]   pend_clr;
  logic [N_REQ-1:0]   eligible;
  logic [VEC_W-1:0]   top_idx;
  logic [N_REQ-1:0]   vec_onehot;

  assign edge_set   = req_q & ~req_n;
  assign eligible   = pending_q & ~mask_q;
  assign vec_onehot = N_REQ'(1) << vector_q;

  // Highest set index wins: later iterations overwrite earlier ones.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (eligible[i]) top_idx = VEC_W'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_q         <= '1;
      pending_q     <= '0;
      mask_q        <= '1;
      in_service_q  <= '0;
      irq_q         <= 1'b0;
      vector_q      <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_n;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      in_service_q  <= in_service_d;
      irq_q         <= irq_d;
      vector_q      <= vector_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    pend_clr      = '0;
    in_service_d  = in_service_q;
    irq_d         = irq_q;
    vector_d      = vector_q;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    mask_d        = mask_we ? mask_wdata : mask_q;

    unique case (state_q)
      StIdle: begin
        if (eligible != '0) begin
          vector_d = top_idx;
          irq_d    = 1'b1;
          cnt_d    = '0;
          state_d  = StAssert;
        end
      end
      StAssert: begin
        // ack takes precedence over an expiring timeout.
        if (ack) begin
          irq_d        = 1'b0;
          pend_clr     = vec_onehot;
          in_service_d = vec_onehot;
          state_d      = StService;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          irq_d         = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StService: begin
        if (eoi) begin
          in_service_d = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh edge in the ack cycle survives the clear so the line is re-presented.
    pending_d = (pending_q & ~pend_clr) | edge_set;
  end

  // Outputs.
  always_comb begin
    irq         = irq_q;
    vector      = vector_q;
    pending     = pending_q;
    in_service  = in_service_q;
    mask        = mask_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_irq_priority_controller.sv
module tb_irq_priority_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vector;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int hi_cnt;
  int pulses;

  irq_priority_controller #(
    .N_REQ      (8),
    .VEC_W      (3),
    .ACK_TIMEOUT(16),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_n      (req_n),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .vector     (vector),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_n = 8'hFF;
    mask_we = 1'b0;
    mask_wdata = 8'h00;
    ack = 1'b0;
    eoi = 1'b0;
    #12;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_mask", 32'(mask), 32'hFF);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_in_service", 32'(in_service), 32'h0);
    check("rst_vector", 32'(vector), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: single line 2
    write_mask(8'h00);
    check("t1_mask", 32'(mask), 32'h00);
    req_n = 8'hFB;
    step();
    check("t1_pending", 32'(pending), 32'h04);
    check("t1_irq_early", 32'(irq), 32'h0);
    step();
    check("t1_irq", 32'(irq), 32'h1);
    check("t1_vector", 32'(vector), 32'h2);
    do_ack();
    check("t1_ack_irq", 32'(irq), 32'h0);
    check("t1_ack_insvc", 32'(in_service), 32'h04);
    check("t1_ack_pending", 32'(pending), 32'h00);
    do_eoi();
    check("t1_eoi_insvc", 32'(in_service), 32'h00);
    req_n = 8'hFF;
    step();

    // 2: simultaneous edges on lines 0, 5, 7
    req_n = 8'h5E;
    step();
    check("t2_pending", 32'(pending), 32'hA1);
    step();
    check("t2_vec7", 32'(vector), 32'h7);
    check("t2_irq7", 32'(irq), 32'h1);
    do_ack();
    check("t2_insvc7", 32'(in_service), 32'h80);
    check("t2_pend_after7", 32'(pending), 32'h21);
    do_eoi();
    step();
    check("t2_vec5", 32'(vector), 32'h5);
    do_ack();
    do_eoi();
    step();
    check("t2_vec0", 32'(vector), 32'h0);
    check("t2_irq0", 32'(irq), 32'h1);
    do_ack();
    check("t2_pend_end", 32'(pending), 32'h00);
    do_eoi();
    req_n = 8'hFF;
    step();

    // 3: line 7 masked
    write_mask(8'h80);
    req_n = 8'h77;
    step();
    check("t3_pending", 32'(pending), 32'h88);
    step();
    check("t3_vec3", 32'(vector), 32'h3);
    do_ack();
    check("t3_pend_keep7", 32'(pending), 32'h80);
    do_eoi();
    step();
    check("t3_no_irq_masked", 32'(irq), 32'h0);
    write_mask(8'h00);
    step();
    check("t3_irq7", 32'(irq), 32'h1);
    check("t3_vec7", 32'(vector), 32'h7);
    do_ack();
    do_eoi();
    req_n = 8'hFF;
    step();

    // 4: ack timeout on line 4
    req_n = 8'hEF;
    step();
    step();
    check("t4_irq_rise", 32'(irq), 32'h1);
    hi_cnt = 0;
    pulses = 0;
    while (irq && hi_cnt < 40) begin
      hi_cnt++;
      step();
    end
    check("t4_irq_high_cycles", 32'(hi_cnt), 32'd16);
    check("t4_timeout_err", 32'(timeout_err), 32'h1);
    check("t4_pending_kept", 32'(pending[4]), 32'h1);
    if (timeout_err) pulses++;
    step();
    if (timeout_err) pulses++;
    check("t4_pulse_once", 32'(pulses), 32'd1);
    check("t4_reassert", 32'(irq), 32'h1);
    check("t4_vec4", 32'(vector), 32'h4);
    do_ack();
    do_eoi();
    req_n = 8'hFF;
    step();

    // 5: new edge on line 6 in the ack cycle
    req_n = 8'hBF;
    step();
    step();
    check("t5_vec6", 32'(vector), 32'h6);
    req_n = 8'hFF;
    step();
    req_n = 8'hBF;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t5_pend6_set", 32'(pending[6]), 32'h1);
    check("t5_insvc", 32'(in_service), 32'h40);
    do_eoi();
    step();
    check("t5_represent_irq", 32'(irq), 32'h1);
    check("t5_represent_vec", 32'(vector), 32'h6);
    do_ack();
    do_eoi();
    check("t5_pend_end", 32'(pending), 32'h00);
    req_n = 8'hFF;
    step();

    // 6: async reset mid-ASSERT
    req_n = 8'hFD;
    step();
    step();
    check("t6_irq_pre", 32'(irq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_irq", 32'(irq), 32'h0);
    check("t6_async_mask", 32'(mask), 32'hFF);
    check("t6_async_pend", 32'(pending), 32'h00);
    req_n = 8'hFF;
    #1;
    rst_n = 1'b1;
    step();
    ack = 1'b1;
    eoi = 1'b1;
    step();
    ack = 1'b0;
    eoi = 1'b0;
    check("t6_ack_ignored", 32'(in_service), 32'h00);
    check("t6_no_irq", 32'(irq), 32'h0);
    write_mask(8'h00);
    step();
    check("t6_no_irq_unmasked", 32'(irq), 32'h0);
    req_n = 8'hFB;
    step();
    step();
    check("t6_new_irq", 32'(irq), 32'h1);
    check("t6_new_vec", 32'(vector), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
